frm_buf_sched: RTL and testbench
================================

Name: frm_buf_sched

Overview:
Triple-buffer scheduler for the 2D accelerator's DDR frame buffers, in the display clock domain. Grants the accelerator (writer) a free buffer per frame, tracks completed frames, and swaps the display (reader) buffer only on vsync rising edges, so the scan-out never tears. Exports per-buffer base addresses plus swap, repeat and drop statistics for software and debug.

Parameters:
ADDR_W, 32, width of DDR byte addresses
BASE_ADDR, 32'h0000_0000, DDR byte address of buffer 0
FRM_BYTES, 32'h0020_0000, byte stride between buffers; buffer i base = BASE_ADDR + i*FRM_BYTES

Ports:
disp_clk  in  1  display clock; the only clock
disp_rst  in  1  synchronous, active-high reset
vsync  in  1  display vsync, level; synchronised and edge-detected internally
wr_req  in  1  writer requests a buffer for a new frame; level, sampled only in IDLE
wr_done  in  1  one-cycle pulse: writer finished the granted buffer
wr_gnt  out  1  one-cycle pulse: wr_buf_idx and wr_base_addr are valid
wr_busy  out  1  high from grant until wr_done
wr_buf_idx  out  2  buffer granted to the writer
wr_base_addr  out  ADDR_W  base address of wr_buf_idx
rd_buf_idx  out  2  buffer being displayed
rd_base_addr  out  ADDR_W  base address of rd_buf_idx
swap_cnt  out  9  vsyncs that swapped to a new frame; wraps at 511
repeat_cnt  out  8  vsyncs with no new frame ready; saturates at 255
drop_cnt  out  8  completed frames discarded before display; saturates at 255
err  out  1  sticky: wr_done received while not WRITING

Behaviour:
- Each buffer (0..2) holds one state: FREE, WRITING, READY or DISPLAY. Invariants: exactly one DISPLAY, at most one WRITING, at most one READY.
- Reset (disp_rst high at a clock edge, including mid-write):
  - buf0 = DISPLAY; buf1 and buf2 = FREE; writer FSM = IDLE.
  - All outputs 0, except both base addrs = BASE_ADDR.
  - vsync sync flops = 0.
  - Any in-progress frame is abandoned and a later wr_done is treated as an error.
- vsync path: 2-flop shift register. rise = (ff == 2'b01). If vsync is first sampled high at edge k, the swap takes effect at edge k+1.
- Writer FSM, IDLE -> WRITING:
  - Condition: wr_req sampled high in IDLE.
  - Target: the lowest-index FREE buffer. If no buffer is FREE, reclaim the READY buffer and increment drop_cnt.
  - At the next edge: wr_gnt=1 for exactly one cycle; wr_buf_idx and wr_base_addr load; wr_busy=1; target buffer = WRITING. Grant latency is 1 cycle.
- Writer FSM, WRITING -> IDLE:
  - Condition: wr_done. The buffer goes READY and wr_busy goes 0 at the next edge.
  - If another READY buffer already exists, it becomes FREE (newest frame wins) and drop_cnt increments.
  - wr_req is ignored while WRITING. The FSM can issue a new grant in the cycle after it returns to IDLE.
- wr_done in IDLE: no state change; err is set and stays set until reset.
- Swap on rise:
  - If a READY buffer exists: the current DISPLAY buffer goes FREE, READY goes DISPLAY, rd_buf_idx and rd_base_addr update, swap_cnt increments.
  - Otherwise: the display is unchanged and repeat_cnt increments.
- Simultaneous events, same cycle:
  - wr_done + rise: the just-completed buffer goes straight to DISPLAY. Any older READY buffer is freed and counted as a drop. The old DISPLAY buffer is freed.
  - Grant + rise: the grant target is chosen from the pre-swap FREE set. A buffer freed by this swap is eligible from the next cycle.
  - Grant with no FREE buffer + rise with a READY buffer in the same cycle: the swap takes the READY buffer, and the grant targets the old DISPLAY buffer. No drop is counted.
- Address arithmetic: base = BASE_ADDR + idx*FRM_BYTES, computed in ADDR_W bits (modulo 2^ADDR_W). Both base addresses are registered and update on the same edge as their idx.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then wr_req high at cycle 5 -> wr_gnt pulses at cycle 6, wr_buf_idx=1, wr_base_addr=32'h0020_0000, wr_busy=1; rd_buf_idx=0.
- wr_done, then vsync rising -> rd_buf_idx=1 one cycle after the first high sample, rd_base_addr=32'h0020_0000, swap_cnt=1. Next wr_req -> wr_buf_idx=0.
- 3 vsync pulses with no wr_done -> rd_buf_idx unchanged, repeat_cnt=3, swap_cnt=0.
- Two full grant/done cycles between vsyncs (buffers 1 then 2) -> drop_cnt=1; after vsync, rd_buf_idx=2 and buf1 is FREE (the next grant targets 1).
- wr_done in the same cycle rise is detected, with an older READY buffer present -> the new buffer is displayed, drop_cnt increments, swap_cnt increments once.
- wr_done while IDLE -> err=1 and no state change; assert disp_rst mid-write -> all reset values next cycle, err=0, rd_buf_idx=0.

Source files
------------

// File: rtl/frm_buf_sched.sv
// Triple-buffer scheduler: grants the writer a free frame buffer and swaps the
// display buffer only on vsync rising edges so scan-out never tears.
module frm_buf_sched #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] FRM_BYTES = ADDR_W'(32'h0020_0000)
) (
  input  logic              disp_clk_i,
  input  logic              disp_rst_i,
  input  logic              vsync_i,
  input  logic              wr_req_i,
  input  logic              wr_done_i,
  output logic              wr_gnt_o,
  output logic              wr_busy_o,
  output logic [1:0]        wr_buf_idx_o,
  output logic [ADDR_W-1:0] wr_base_addr_o,
  output logic [1:0]        rd_buf_idx_o,
  output logic [ADDR_W-1:0] rd_base_addr_o,
  output logic [8:0]        swap_cnt_o,
  output logic [7:0]        repeat_cnt_o,
  output logic [7:0]        drop_cnt_o,
  output logic              err_o
);

  typedef enum logic [1:0] {BufFree, BufWriting, BufReady, BufDisplay} buf_st_e;
  typedef enum logic {StIdle, StWriting} wr_st_e;

  buf_st_e buf_q [3];
  buf_st_e buf_d [3];
  wr_st_e  wr_st_q, wr_st_d;

  logic [1:0]        vs_q;
  logic [1:0]        wr_idx_q, wr_idx_d;
  logic [1:0]        rd_idx_q, rd_idx_d;
  logic              gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [8:0]        swap_q, swap_d;
  logic [7:0]        rep_q, rep_d;
  logic [7:0]        drop_q, drop_d;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;

  logic       rise, done, grant, drop_inc;
  logic       free_vld, rdy_vld, swap_vld;
  logic [1:0] free_idx, rdy_idx, swap_idx, tgt_idx;

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * FRM_BYTES;
  endfunction

  // vs_q[1] is the older sample
  assign rise  = (vs_q == 2'b01);
  assign done  = (wr_st_q == StWriting) && wr_done_i;
  assign grant = (wr_st_q == StIdle) && wr_req_i;

  always_comb begin
    buf_d    = buf_q;
    wr_st_d  = wr_st_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    gnt_d    = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    swap_d   = swap_q;
    rep_d    = rep_q;
    drop_d   = drop_q;
    drop_inc = 1'b0;
    free_vld = 1'b0;
    free_idx = 2'd0;
    rdy_vld  = 1'b0;
    rdy_idx  = 2'd0;
    tgt_idx  = 2'd0;

    // Descending scan leaves the lowest matching index
    for (int i = 2; i >= 0; i--) begin
      if (buf_q[i] == BufFree) begin
        free_vld = 1'b1;
        free_idx = 2'(i);
      end
      if (buf_q[i] == BufReady) begin
        rdy_vld = 1'b1;
        rdy_idx = 2'(i);
      end
    end

    if (wr_done_i && wr_st_q != StWriting) err_d = 1'b1;

    if (done) begin
      if (rdy_vld) begin
        buf_d[rdy_idx] = BufFree;
        drop_inc       = 1'b1;
      end
      buf_d[wr_idx_q] = BufReady;
      wr_st_d         = StIdle;
      busy_d          = 1'b0;
    end

    // A frame completing this cycle is newer than any older READY one
    swap_vld = done || rdy_vld;
    swap_idx = done ? wr_idx_q : rdy_idx;
    if (rise) begin
      if (swap_vld) begin
        buf_d[rd_idx_q] = BufFree;
        buf_d[swap_idx] = BufDisplay;
        rd_idx_d        = swap_idx;
        swap_d          = swap_q + 9'd1;
      end else if (rep_q != 8'hff) begin
        rep_d = rep_q + 8'd1;
      end
    end

    if (grant) begin
      if (free_vld) begin
        tgt_idx = free_idx;
      end else if (rise && rdy_vld) begin
        tgt_idx = rd_idx_q;
      end else begin
        tgt_idx  = rdy_idx;
        drop_inc = 1'b1;
      end
      buf_d[tgt_idx] = BufWriting;
      wr_idx_d       = tgt_idx;
      gnt_d          = 1'b1;
      busy_d         = 1'b1;
      wr_st_d        = StWriting;
    end

    if (drop_inc && drop_q != 8'hff) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge disp_clk_i) begin
    if (disp_rst_i) begin
      buf_q[0]  <= BufDisplay;
      buf_q[1]  <= BufFree;
      buf_q[2]  <= BufFree;
      wr_st_q   <= StIdle;
      vs_q      <= 2'b00;
      wr_idx_q  <= 2'd0;
      rd_idx_q  <= 2'd0;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      swap_q    <= 9'd0;
      rep_q     <= 8'd0;
      drop_q    <= 8'd0;
      wr_addr_q <= BASE_ADDR;
      rd_addr_q <= BASE_ADDR;
    end else begin
      buf_q     <= buf_d;
      wr_st_q   <= wr_st_d;
      vs_q      <= {vs_q[0], vsync_i};
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      swap_q    <= swap_d;
      rep_q     <= rep_d;
      drop_q    <= drop_d;
      wr_addr_q <= base_of(wr_idx_d);
      rd_addr_q <= base_of(rd_idx_d);
    end
  end

  assign wr_gnt_o       = gnt_q;
  assign wr_busy_o      = busy_q;
  assign wr_buf_idx_o   = wr_idx_q;
  assign wr_base_addr_o = wr_addr_q;
  assign rd_buf_idx_o   = rd_idx_q;
  assign rd_base_addr_o = rd_addr_q;
  assign swap_cnt_o     = swap_q;
  assign repeat_cnt_o   = rep_q;
  assign drop_cnt_o     = drop_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_frm_buf_sched.sv
// Bench for frm_buf_sched: directed scenarios plus randomized traffic checked
// against a per-buffer state model.
module tb_frm_buf_sched;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] FRM  = 32'h0020_0000;

  logic        clk = 1'b0;
  logic        rst, vsync, wr_req, wr_done;
  logic        wr_gnt, wr_busy, err;
  logic [1:0]  wr_buf_idx, rd_buf_idx;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic [8:0]  swap_cnt;
  logic [7:0]  repeat_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frm_buf_sched #(
    .ADDR_W   (32),
    .BASE_ADDR(BASE),
    .FRM_BYTES(FRM)
  ) dut (
    .disp_clk_i    (clk),
    .disp_rst_i    (rst),
    .vsync_i       (vsync),
    .wr_req_i      (wr_req),
    .wr_done_i     (wr_done),
    .wr_gnt_o      (wr_gnt),
    .wr_busy_o     (wr_busy),
    .wr_buf_idx_o  (wr_buf_idx),
    .wr_base_addr_o(wr_base_addr),
    .rd_buf_idx_o  (rd_buf_idx),
    .rd_base_addr_o(rd_base_addr),
    .swap_cnt_o    (swap_cnt),
    .repeat_cnt_o  (repeat_cnt),
    .drop_cnt_o    (drop_cnt),
    .err_o         (err)
  );

  // Model: 0 free, 1 writing, 2 ready, 3 display
  int m_st [3];
  bit m_wr, m_gnt, m_err, m_vs0, m_vs1;
  int m_widx, m_ridx, m_swap, m_rep, m_drop;

  function automatic int find_st(input int s);
    for (int i = 0; i < 3; i++) if (m_st[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_base(input int idx);
    return BASE + 32'(idx) * FRM;
  endfunction

  task automatic model_edge();
    bit rise, done, grant;
    int fr, rd, old_disp, tgt;
    if (rst) begin
      m_st[0] = 3; m_st[1] = 0; m_st[2] = 0;
      m_wr = 0; m_gnt = 0; m_err = 0; m_vs0 = 0; m_vs1 = 0;
      m_widx = 0; m_ridx = 0; m_swap = 0; m_rep = 0; m_drop = 0;
      return;
    end
    rise = m_vs0 && !m_vs1;
    m_vs1 = m_vs0;
    m_vs0 = vsync;
    done  = m_wr && wr_done;
    grant = !m_wr && wr_req;
    if (wr_done && !m_wr) m_err = 1;
    fr = find_st(0);
    old_disp = m_ridx;
    m_gnt = grant;
    if (done) begin
      rd = find_st(2);
      if (rd >= 0) begin
        m_st[rd] = 0;
        if (m_drop < 255) m_drop++;
      end
      m_st[m_widx] = 2;
      m_wr = 0;
    end
    if (rise) begin
      rd = find_st(2);
      if (rd >= 0) begin
        m_st[m_ridx] = 0;
        m_st[rd] = 3;
        m_ridx = rd;
        m_swap = (m_swap + 1) % 512;
      end else if (m_rep < 255) m_rep++;
    end
    if (grant) begin
      if (fr >= 0) tgt = fr;
      else if (rise && m_ridx != old_disp) tgt = old_disp;
      else begin
        tgt = find_st(2);
        if (m_drop < 255) m_drop++;
      end
      m_st[tgt] = 1;
      m_widx = tgt;
      m_wr = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; vsync = 0; wr_req = 0; wr_done = 0;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (wr_gnt !== 1'b0 || wr_busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: gnt=%b busy=%b err=%b want 0 0 0", wr_gnt, wr_busy, err);
    end
    if (wr_buf_idx !== 2'd0 || rd_buf_idx !== 2'd0) begin
      errors++; $display("FAIL reset_idx: wr=%0d rd=%0d want 0 0", wr_buf_idx, rd_buf_idx);
    end
    if (wr_base_addr !== BASE) begin
      errors++; $display("FAIL reset_wr_addr: got %h want %h", wr_base_addr, BASE);
    end
    if (rd_base_addr !== BASE) begin
      errors++; $display("FAIL reset_rd_addr: got %h want %h", rd_base_addr, BASE);
    end
    if (swap_cnt !== 9'd0 || repeat_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnts: swap=%0d rep=%0d want 0 0", swap_cnt, repeat_cnt);
    end
    if (drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt);
    end
  endtask

  task automatic test_grant();
    repeat (4) step();
    wr_req = 1; step(); wr_req = 0;
    checks += 4;
    if (wr_gnt !== 1'b1 || wr_busy !== 1'b1) begin
      errors++; $display("FAIL grant_pulse: gnt=%b busy=%b want 1 1", wr_gnt, wr_busy);
    end
    if (wr_buf_idx !== 2'd1 || wr_base_addr !== 32'h0020_0000) begin
      errors++; $display("FAIL grant_idx: idx=%0d addr=%h want 1 00200000", wr_buf_idx, wr_base_addr);
    end
    if (rd_buf_idx !== 2'd0) begin
      errors++; $display("FAIL grant_rd: got %0d want 0", rd_buf_idx);
    end
    step();
    if (wr_gnt !== 1'b0 || wr_busy !== 1'b1) begin
      errors++; $display("FAIL grant_one_cycle: gnt=%b busy=%b want 0 1", wr_gnt, wr_busy);
    end
  endtask

  task automatic test_swap();
    wr_done = 1; step(); wr_done = 0;
    checks += 5;
    if (wr_busy !== 1'b0 || rd_buf_idx !== 2'd0) begin
      errors++; $display("FAIL done_busy: busy=%b rd=%0d want 0 0", wr_busy, rd_buf_idx);
    end
    vsync = 1; step();
    if (rd_buf_idx !== 2'd0) begin
      errors++; $display("FAIL swap_early: rd=%0d want 0", rd_buf_idx);
    end
    step(); vsync = 0;
    if (rd_buf_idx !== 2'd1 || rd_base_addr !== 32'h0020_0000) begin
      errors++; $display("FAIL swap_rd: rd=%0d addr=%h want 1 00200000", rd_buf_idx, rd_base_addr);
    end
    if (swap_cnt !== 9'd1) begin
      errors++; $display("FAIL swap_cnt: got %0d want 1", swap_cnt);
    end
    wr_req = 1; step(); wr_req = 0;
    if (wr_buf_idx !== 2'd0 || wr_base_addr !== BASE) begin
      errors++; $display("FAIL swap_regrant: idx=%0d addr=%h want 0 %h", wr_buf_idx, wr_base_addr, BASE);
    end
    wr_done = 1; step(); wr_done = 0;
  endtask

  task automatic test_repeat();
    do_reset();
    repeat (3) begin
      vsync = 1; step(); step();
      vsync = 0; step(); step();
    end
    checks += 2;
    if (rd_buf_idx !== 2'd0 || swap_cnt !== 9'd0) begin
      errors++; $display("FAIL repeat_rd: rd=%0d swap=%0d want 0 0", rd_buf_idx, swap_cnt);
    end
    if (repeat_cnt !== 8'd3) begin
      errors++; $display("FAIL repeat_cnt: got %0d want 3", repeat_cnt);
    end
  endtask

  task automatic test_drop();
    do_reset();
    repeat (2) begin
      wr_req = 1; step(); wr_req = 0; step();
      wr_done = 1; step(); wr_done = 0;
    end
    checks += 4;
    if (wr_buf_idx !== 2'd2 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL drop_second: idx=%0d drop=%0d want 2 1", wr_buf_idx, drop_cnt);
    end
    wr_req = 1; step(); wr_req = 0;
    if (wr_buf_idx !== 2'd1) begin
      errors++; $display("FAIL drop_freed: idx=%0d want 1", wr_buf_idx);
    end
    vsync = 1; step(); step(); vsync = 0; step();
    if (rd_buf_idx !== 2'd2 || rd_base_addr !== 32'h0040_0000) begin
      errors++; $display("FAIL drop_rd: rd=%0d addr=%h want 2 00400000", rd_buf_idx, rd_base_addr);
    end
    if (swap_cnt !== 9'd1 || drop_cnt !== 8'd1) begin
      errors++; $display("FAIL drop_cnts: swap=%0d drop=%0d want 1 1", swap_cnt, drop_cnt);
    end
    wr_done = 1; step(); wr_done = 0;
  endtask

  task automatic test_done_rise();
    do_reset();
    wr_req = 1; step(); wr_req = 0;
    wr_done = 1; step(); wr_done = 0;
    wr_req = 1; step(); wr_req = 0;
    checks += 4;
    if (wr_buf_idx !== 2'd2) begin
      errors++; $display("FAIL dr_grant: idx=%0d want 2", wr_buf_idx);
    end
    vsync = 1; step();
    wr_done = 1; step(); wr_done = 0; vsync = 0;
    if (rd_buf_idx !== 2'd2 || wr_busy !== 1'b0) begin
      errors++; $display("FAIL dr_rd: rd=%0d busy=%b want 2 0", rd_buf_idx, wr_busy);
    end
    if (drop_cnt !== 8'd1 || repeat_cnt !== 8'd0) begin
      errors++; $display("FAIL dr_drop: drop=%0d rep=%0d want 1 0", drop_cnt, repeat_cnt);
    end
    step(); step();
    if (swap_cnt !== 9'd1) begin
      errors++; $display("FAIL dr_swap: got %0d want 1", swap_cnt);
    end
  endtask

  task automatic test_err();
    do_reset();
    wr_done = 1; step(); wr_done = 0;
    checks += 5;
    if (err !== 1'b1 || wr_busy !== 1'b0 || rd_buf_idx !== 2'd0 || wr_gnt !== 1'b0) begin
      errors++; $display("FAIL err_idle: err=%b busy=%b rd=%0d gnt=%b want 1 0 0 0", err, wr_busy, rd_buf_idx, wr_gnt);
    end
    step();
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err);
    end
    wr_req = 1; step(); wr_req = 0;
    if (wr_busy !== 1'b1 || wr_buf_idx !== 2'd1) begin
      errors++; $display("FAIL err_grant: busy=%b idx=%0d want 1 1", wr_busy, wr_buf_idx);
    end
    rst = 1; step(); rst = 0;
    if (err !== 1'b0 || wr_busy !== 1'b0 || rd_buf_idx !== 2'd0 || wr_buf_idx !== 2'd0 ||
        wr_base_addr !== BASE || rd_base_addr !== BASE) begin
      errors++; $display("FAIL err_midreset: err=%b busy=%b rd=%0d wr=%0d waddr=%h raddr=%h want all reset",
                         err, wr_busy, rd_buf_idx, wr_buf_idx, wr_base_addr, rd_base_addr);
    end
    wr_done = 1; step(); wr_done = 0;
    if (err !== 1'b1 || wr_busy !== 1'b0) begin
      errors++; $display("FAIL err_abandoned: err=%b busy=%b want 1 0", err, wr_busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst     = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) vsync = ~vsync;
      wr_req  = ($urandom_range(0, 2) == 0);
      wr_done = m_wr ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
      step();
      checks++;
      if (wr_gnt !== m_gnt || wr_busy !== m_wr || err !== m_err ||
          wr_buf_idx !== 2'(m_widx) || wr_base_addr !== exp_base(m_widx) ||
          rd_buf_idx !== 2'(m_ridx) || rd_base_addr !== exp_base(m_ridx) ||
          swap_cnt !== 9'(m_swap) || repeat_cnt !== 8'(m_rep) || drop_cnt !== 8'(m_drop)) begin
        errors++;
        $display("FAIL random cyc %0d: got gnt=%b busy=%b err=%b widx=%0d wa=%h ridx=%0d ra=%h sw=%0d rp=%0d dr=%0d; want %b %b %b %0d %h %0d %h %0d %0d %0d",
                 cyc, wr_gnt, wr_busy, err, wr_buf_idx, wr_base_addr, rd_buf_idx, rd_base_addr,
                 swap_cnt, repeat_cnt, drop_cnt, m_gnt, m_wr, m_err, m_widx, exp_base(m_widx),
                 m_ridx, exp_base(m_ridx), m_swap, m_rep, m_drop);
      end
    end
    rst = 0; wr_req = 0; wr_done = 0; vsync = 0;
  endtask

  initial begin
    test_reset();
    test_grant();
    test_swap();
    test_repeat();
    test_drop();
    test_done_rise();
    test_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
